// File: rtl/drive_sync_fifo.sv
// drive_sync_fifo: synchronises an asynchronous token request (i_drive),
// captures the token payload into a small first-word-fall-through FIFO, and
// returns a registered o_free pulse upstream once the token has a home.
// If the push fills the FIFO, o_free is held back until the first pop.
module drive_sync_fifo #(
   parameter int DATA_WIDTH        = 32,
   parameter int DEPTH             = 4,
   parameter int SYNC_STAGES       = 2,
   parameter int FREE_PULSE_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_drive,
   input  logic [DATA_WIDTH-1:0]        i_data,
   output logic                         o_free,
   output logic                         o_valid,
   output logic [DATA_WIDTH-1:0]        o_data,
   input  logic                         i_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PC_W  = $clog2(FREE_PULSE_CYCLES) + 1;

   localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(FREE_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_SPACE = 2'd1,
      PULSE      = 2'd2
   } free_state_t;

   // ---------------------------------------------------------------------
   // Synchronizer chain and rising-edge detector
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   edge_reg;
   logic                   detect;

   genvar gi;
   assign sync_next[0] = i_drive;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         assign sync_next[gi] = sync_reg[gi-1];
      end
   endgenerate

   // Shift i_drive through the chain; edge_reg keeps the previous last stage.
   // Clearing edge_reg on reset makes a level still high at release count as new.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= '0;
         edge_reg <= 1'b0;
      end else begin
         sync_reg <= sync_next;
         edge_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign detect = sync_reg[SYNC_STAGES-1] & ~edge_reg;

   // ---------------------------------------------------------------------
   // FIFO storage, pointers and occupancy
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [CNT_W-1:0]      count_reg;
   logic [CNT_W-1:0]      count_next;
   logic                  pop;
   logic                  push;
   logic                  full;

   assign o_valid = (count_reg != '0);
   assign full    = (count_reg == DEPTH_C);
   assign pop     = o_valid & i_ready;
   // A full FIFO still takes the token when the head leaves on the same edge.
   assign push    = detect & (~full | pop);

   // Occupancy after this edge; push and pop together cancel out.
   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   // Payload write; storage needs no reset because count_reg qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

   // First-word-fall-through head: the slot at rd_ptr is presented directly,
   // so a pop exposes the next entry with no bubble. Zero when empty.
   assign o_data  = o_valid ? mem_reg[rd_ptr_reg] : '0;
   assign o_count = count_reg;

   // ---------------------------------------------------------------------
   // Free-pulse FSM
   // ---------------------------------------------------------------------
   free_state_t      state_reg;
   free_state_t      state_next;
   logic [PC_W-1:0]  pulse_cnt_reg;
   logic [PC_W-1:0]  pulse_cnt_next;
   logic             free_reg;

   // Next-state logic: only an accepted push from IDLE or a pop while
   // waiting for space starts a release pulse.
   always_comb begin
      state_next     = state_reg;
      pulse_cnt_next = pulse_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (push) begin
               pulse_cnt_next = '0;
               state_next     = (count_next == DEPTH_C) ? WAIT_SPACE : PULSE;
            end
         end
         WAIT_SPACE: begin
            if (pop) begin
               pulse_cnt_next = '0;
               state_next     = PULSE;
            end
         end
         PULSE: begin
            if (pulse_cnt_reg == PULSE_LAST) begin
               pulse_cnt_next = '0;
               state_next     = IDLE;
            end else begin
               pulse_cnt_next = pulse_cnt_reg + PC_W'(1);
            end
         end
         default: begin
            pulse_cnt_next = '0;
            state_next     = IDLE;
         end
      endcase
   end

   // State register; o_free is registered from the next state so it is high
   // exactly for the cycles spent in PULSE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pulse_cnt_reg <= '0;
         free_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pulse_cnt_reg <= pulse_cnt_next;
         free_reg      <= (state_next == PULSE);
      end
   end

   assign o_free = free_reg;

   // ---------------------------------------------------------------------
   // Sticky protocol-violation flag
   // ---------------------------------------------------------------------
   logic overflow_reg;
   logic overflow_set;

   // A dropped token is always a violation. A token arriving before upstream
   // was released is one too, except in WAIT_SPACE on a pop edge: that pop is
   // exactly the event that would have released upstream, so the token fits.
   assign overflow_set = detect & (~push
                                   | (state_reg == PULSE)
                                   | ((state_reg == WAIT_SPACE) & ~pop));

   // Set-only flag, cleared solely by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_reg <= 1'b0;
      end else if (overflow_set) begin
         overflow_reg <= 1'b1;
      end
   end

   assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_drive_sync_fifo.sv
// Testbench for drive_sync_fifo: directed token scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_drive_sync_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int FREE  = 2;

   logic          clk;
   logic          rst;
   logic          i_drive;
   logic [DW-1:0] i_data;
   logic          o_free;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          i_ready;
   logic [2:0]    o_count;
   logic          o_overflow;

   int checks_cnt;
   int fail_cnt;
   bit rdy_rand;

   drive_sync_fifo #(
      .DATA_WIDTH        (DW),
      .DEPTH             (DEPTH),
      .SYNC_STAGES       (SYNC),
      .FREE_PULSE_CYCLES (FREE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_drive    (i_drive),
      .i_data     (i_data),
      .o_free     (o_free),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .i_ready    (i_ready),
      .o_count    (o_count),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: i_drive sample history, a data queue, a release
   // countdown and a "release owed on next pop" flag.
   // ------------------------------------------------------------------
   logic [15:0]   hist;
   logic [DW-1:0] q[$];
   bit            m_ovf;
   int            free_left;
   bit            waiting;

   always @(posedge clk) begin
      bit det, pop, acc, in_pulse;
      if (rst) begin
         hist      = '0;
         q.delete();
         m_ovf     = 1'b0;
         free_left = 0;
         waiting   = 1'b0;
      end else begin
         // A token is seen SYNC edges after the first sample of a rising level.
         det  = hist[SYNC-1] && !hist[SYNC];
         hist = {hist[14:0], i_drive};
         pop  = (q.size() > 0) && i_ready;
         acc  = det && ((q.size() < DEPTH) || pop);
         in_pulse = (free_left > 0);
         if (det && (!acc || in_pulse || (waiting && !pop))) m_ovf = 1'b1;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(i_data);
         if (in_pulse) begin
            free_left--;
         end else if (waiting) begin
            if (pop) begin
               waiting   = 1'b0;
               free_left = FREE;
            end
         end else if (acc) begin
            if (q.size() == DEPTH) waiting = 1'b1;
            else free_left = FREE;
         end
         if (det) begin
            $display("token data=0x%08h accepted=%0d count=%0d ovf=%0d t=%0t",
                     i_data, acc, q.size(), m_ovf, $time);
         end
      end
      #1;
      check_val("valid", {31'b0, o_valid}, {31'b0, (q.size() > 0)});
      check_val("data", o_data, (q.size() > 0) ? q[0] : 32'h0);
      check_val("count", {29'b0, o_count}, 32'(q.size()));
      check_val("free", {31'b0, o_free}, {31'b0, (free_left > 0)});
      check_val("overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
      if (rdy_rand) i_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic send_token(input logic [DW-1:0] d, input int hold, input int gap);
      i_data  = d;
      i_drive = 1'b1;
      repeat (hold) tick();
      i_drive = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      checks_cnt = 0;
      fail_cnt   = 0;
      rdy_rand   = 1'b0;
      rst        = 1'b1;
      i_drive    = 1'b0;
      i_data     = '0;
      i_ready    = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Single token, no consumer.
      send_token(32'hA5A5_0001, 4, 6);

      // Four tokens fill the FIFO, then one pop releases the last.
      do_reset();
      for (int i = 1; i <= 4; i++) send_token(32'(i), 4, 6);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      repeat (4) tick();

      // Refill to full and inject a token with no pop: dropped, sticky flag.
      send_token(32'h0000_0005, 4, 6);
      send_token(32'h0000_0006, 4, 6);
      i_ready = 1'b1;
      repeat (6) tick();
      i_ready = 1'b0;
      tick();

      // Streaming consumer.
      do_reset();
      i_ready = 1'b1;
      send_token(32'h0000_0010, 4, 6);
      send_token(32'h0000_0011, 4, 6);
      i_ready = 1'b0;

      // Reset while o_free is high, i_drive held across the release.
      do_reset();
      i_data  = 32'h0000_0035;
      i_drive = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      i_drive = 1'b0;
      repeat (6) tick();

      // Full FIFO, push edge coincides with a pop.
      do_reset();
      for (int i = 1; i <= 4; i++) send_token(32'h20 + 32'(i), 4, 6);
      i_data  = 32'h0000_0025;
      i_drive = 1'b1;
      tick();
      tick();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      tick();
      i_drive = 1'b0;
      repeat (6) tick();

      // Randomized traffic with occasional protocol violations and resets.
      do_reset();
      rdy_rand = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         send_token($urandom(), $urandom_range(1, 6), $urandom_range(1, 8));
      end
      rdy_rand = 1'b0;
      i_ready  = 1'b1;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
